// File: rtl/eth_frame_tx.sv
// -----------------------------------------------------------------------------
// eth_frame_tx
//
// Transmit engine for user-programmed Ethernet frames. A frame image is
// written into an internal byte buffer through a 32-bit word port. The engine
// then plays it out, one byte per beat, on an 8-bit AXI4-Stream master toward
// a TEMAC TX port. Frame length, inter-frame gap and the number of frames per
// enable session are programmable. The engine counts completed frames and
// timestamps the first byte of each frame against a shared free-running timer.
//
// Ports
//   clk, rst           single clock; asynchronous active-high reset
//   srst               synchronous soft reset (buffer contents survive)
//   mem_we/waddr/
//   mem_wdata/wstrb    buffer write port; frame byte n = word n/4, lane n%4
//   enable             level; 1 = generate frames
//   frame_size         bytes per frame (0 = none, clamped to C_MAX_FRAME_SIZE)
//   ifg_cycles         idle cycles after a tlast handshake
//   tx_count           frames per enable session (0 = unlimited)
//   current_time       free-running timer sampled on each first-byte handshake
//   busy               engine not idle
//   frames_sent        completed frames since reset (wraps)
//   last_tx_time       timestamp of the latest frame's first byte
//   m_axis_*           8-bit AXI4-Stream master (tuser is tied 0)
// -----------------------------------------------------------------------------
module eth_frame_tx #(
  parameter int C_AXI_WIDTH      = 32,
  parameter int C_MAX_FRAME_SIZE = 2048
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   srst,
  input  logic                                   mem_we,
  input  logic [$clog2(C_MAX_FRAME_SIZE/4)-1:0]  mem_waddr,
  input  logic [C_AXI_WIDTH-1:0]                 mem_wdata,
  input  logic [C_AXI_WIDTH/8-1:0]               mem_wstrb,
  input  logic                                   enable,
  input  logic [15:0]                            frame_size,
  input  logic [15:0]                            ifg_cycles,
  input  logic [31:0]                            tx_count,
  input  logic [63:0]                            current_time,
  output logic                                   busy,
  output logic [63:0]                            frames_sent,
  output logic [63:0]                            last_tx_time,
  output logic [7:0]                             m_axis_tdata,
  output logic                                   m_axis_tuser,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready
);

  localparam int LANES = C_AXI_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int AW    = $clog2(C_MAX_FRAME_SIZE);
  localparam int DEPTH = C_MAX_FRAME_SIZE / LANES;
  localparam int LW    = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(C_MAX_FRAME_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [15:0]       ifg_q, ifg_d;
  logic [15:0]       gap_q, gap_d;
  logic [31:0]       sess_q, sess_d;
  logic [63:0]       sent_q, sent_d;
  logic [63:0]       time_q, time_d;

  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [C_AXI_WIDTH-1:0] rd_word_q;
  logic [LB-1:0]     rd_lane_q;
  logic [7:0]        cur_byte;

  logic [LW-1:0]     size_clamped;
  logic              is_last;
  logic              start_ok;
  logic              begin_load;

  logic [C_AXI_WIDTH-1:0] mem [DEPTH];

  // Frame buffer. The read register only loads when a new byte is requested,
  // so it doubles as the prefetch/output register: a stalled byte is held
  // stable even if the buffer is rewritten, and the next byte is fetched in
  // the same cycle the current one is accepted, so there are no bubbles.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wstrb[i]) begin
          mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_addr[AW-1:LB]];
      rd_lane_q <= rd_addr[LB-1:0];
    end
  end

  always_comb begin
    cur_byte = rd_word_q[7:0];
    for (int i = 0; i < LANES; i++) begin
      if (rd_lane_q == LB'(i)) begin
        cur_byte = rd_word_q[i*8 +: 8];
      end
    end
  end

  assign size_clamped = (frame_size > 16'(C_MAX_FRAME_SIZE)) ? MAX_LEN : frame_size[LW-1:0];
  assign is_last      = (idx_q == (len_q - LW'(1)));

  // Next-state logic. The session count is resolved first so that the
  // start decision made on a tlast handshake already sees this frame.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    ifg_d      = ifg_q;
    gap_d      = gap_q;
    sess_d     = sess_q;
    sent_d     = sent_q;
    time_d     = time_q;
    rd_en      = 1'b0;
    rd_addr    = idx_q[AW-1:0];
    begin_load = 1'b0;

    if ((state_q == S_SEND) && m_axis_tready && is_last && (sess_q != '1)) begin
      sess_d = sess_q + 32'd1;
    end
    if (!enable) begin
      sess_d = '0;
    end
    start_ok = enable && (frame_size != '0) && ((tx_count == '0) || (sess_d < tx_count));

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          begin_load = 1'b1;
        end
      end
      S_LOAD: begin
        rd_en = 1'b1;
        state_d = enable ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (idx_q == '0) begin
            time_d = current_time;
          end
          if (is_last) begin
            sent_d = sent_q + 64'd1;
            if ((ifg_q != '0) && enable) begin
              state_d = S_GAP;
              gap_d   = ifg_q;
            end else if (start_ok) begin
              begin_load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d   = idx_q + LW'(1);
            rd_en   = 1'b1;
            rd_addr = idx_d[AW-1:0];
          end
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gap_q <= 16'd1) begin
          if (start_ok) begin
            begin_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Length and gap are frozen here so mid-frame register changes wait.
    if (begin_load) begin
      state_d = S_LOAD;
      len_d   = size_clamped;
      ifg_d   = ifg_cycles;
      idx_d   = '0;
    end

    if (srst) begin
      state_d = S_IDLE;
      len_d   = '0;
      idx_d   = '0;
      ifg_d   = '0;
      gap_d   = '0;
      sess_d  = '0;
      sent_d  = '0;
      time_d  = '0;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      ifg_q   <= '0;
      gap_q   <= '0;
      sess_q  <= '0;
      sent_q  <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ifg_q   <= ifg_d;
      gap_q   <= gap_d;
      sess_q  <= sess_d;
      sent_q  <= sent_d;
      time_q  <= time_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign frames_sent   = sent_q;
  assign last_tx_time  = time_q;
  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? cur_byte : 8'd0;
  assign m_axis_tlast  = m_axis_tvalid && is_last;
  assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_frame_tx.sv
module tb_eth_frame_tx;

  localparam int MAXF = 2048;
  localparam int WAW  = $clog2(MAXF/4);

  logic            clk;
  logic            rst;
  logic            srst;
  logic            mem_we;
  logic [WAW-1:0]  mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            enable;
  logic [15:0]     frame_size;
  logic [15:0]     ifg_cycles;
  logic [31:0]     tx_count;
  logic [63:0]     current_time;
  logic            busy;
  logic [63:0]     frames_sent;
  logic [63:0]     last_tx_time;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tuser;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  expMem [MAXF];
  logic [63:0] expTime = '0;

  eth_frame_tx #(
    .C_AXI_WIDTH(32),
    .C_MAX_FRAME_SIZE(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .srst(srst),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .enable(enable),
    .frame_size(frame_size),
    .ifg_cycles(ifg_cycles),
    .tx_count(tx_count),
    .current_time(current_time),
    .busy(busy),
    .frames_sent(frames_sent),
    .last_tx_time(last_tx_time),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared timer ticks on the falling edge, so its value is stable for a
  // whole half-period around each rising edge.
  initial begin
    current_time = 64'h0123_4567_89AB_0000;
    forever begin
      @(negedge clk);
      current_time = current_time + 64'd1;
    end
  end

  // Hard stop in case the flow below never completes
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input int size, input int ifg, input int count);
    enable     = en;
    frame_size = 16'(size);
    ifg_cycles = 16'(ifg);
    tx_count   = 32'(count);
  endtask

  task automatic writeWord(input int waddr, input logic [31:0] data, input logic [3:0] strb);
    mem_we    = 1'b1;
    mem_waddr = WAW'(waddr);
    mem_wdata = data;
    mem_wstrb = strb;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) expMem[waddr*4 + i] = data[i*8 +: 8];
    end
    step();
    mem_we = 1'b0;
  endtask

  // Count samples with tvalid low, up to a budget
  task automatic waitValid(input int budget, output int idle);
    idle = 0;
    while (!m_axis_tvalid && idle < budget) begin
      idle++;
      step();
    end
  endtask

  // Receive one frame, comparing each byte to the buffer model, checking that
  // tvalid never drops and that a stalled beat holds steady.
  task automatic receiveFrame(input int readyPct, input int dropAt,
                              output int beats, output int dataErr, output int protoErr);
    int         cyc;
    bit         done;
    bit         stalled;
    bit         rdy;
    logic [7:0] heldData;
    logic       heldLast;
    beats = 0; dataErr = 0; protoErr = 0; cyc = 0; done = 0; stalled = 0;
    heldData = '0; heldLast = 1'b0;
    while (!done && cyc < 6000) begin
      if (beats == dropAt) begin
        enable     = 1'b0;
        frame_size = 16'd5;
      end
      rdy = (int'($urandom_range(99)) < readyPct);
      m_axis_tready = rdy;
      if (!m_axis_tvalid) begin
        protoErr++;
      end else begin
        if (stalled && (m_axis_tdata !== heldData || m_axis_tlast !== heldLast)) protoErr++;
        if (m_axis_tuser !== 1'b0) protoErr++;
      end
      stalled  = m_axis_tvalid && !rdy;
      heldData = m_axis_tdata;
      heldLast = m_axis_tlast;
      if (m_axis_tvalid && rdy) begin
        if (beats == 0) expTime = current_time + 64'd1;
        if (beats < MAXF && m_axis_tdata !== expMem[beats]) dataErr++;
        if (m_axis_tlast) done = 1;
        beats++;
      end
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
  endtask

  // Main directed sequence
  initial begin
    int          idle;
    int          beats;
    int          dErr;
    int          pErr;
    logic [31:0] wd;

    rst = 1'b1; srst = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_wstrb = '0;
    m_axis_tready = 1'b1;
    applyStimulus(1'b0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    step();

    checkOutput("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset frames_sent", frames_sent, 64'd0);
    checkOutput("reset last_tx_time", last_tx_time, 64'd0);
    checkOutput("reset tdata/tlast/tuser", {54'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 64'd0);

    // Buffer image: first two words fixed, the rest a formula pattern,
    // then a partial-strobe overwrite of word 2 (bytes 8 and 10 only).
    writeWord(0, 32'h0403_0201, 4'hF);
    writeWord(1, 32'h0807_0605, 4'hF);
    for (int w = 2; w < MAXF/4; w++) begin
      for (int b = 0; b < 4; b++) wd[b*8 +: 8] = 8'((w*4 + b)*13 + 7);
      writeWord(w, wd, 4'hF);
    end
    writeWord(2, 32'hAABB_CCDD, 4'b0101);

    // Test 1: six-byte frame, one per session
    $display("[TB] test 1: 6-byte single frame");
    applyStimulus(1'b1, 6, 0, 1);
    waitValid(10, idle);
    checkOutput("t1 start latency", 64'(idle), 64'd2);
    receiveFrame(100, -1, beats, dErr, pErr);
    checkOutput("t1 beats", 64'(beats), 64'd6);
    checkOutput("t1 data errors", 64'(dErr), 64'd0);
    checkOutput("t1 protocol errors", 64'(pErr), 64'd0);
    checkOutput("t1 frames_sent", frames_sent, 64'd1);
    checkOutput("t1 busy after frame", 64'(busy), 64'd0);
    checkOutput("t1 last_tx_time", last_tx_time, expTime);
    waitValid(10, idle);
    checkOutput("t1 no second frame", 64'(idle), 64'd10);

    // Test 2: three 64-byte frames with a 12-cycle gap
    $display("[TB] test 2: 3 frames, ifg 12");
    applyStimulus(1'b0, 64, 12, 3);
    step();
    applyStimulus(1'b1, 64, 12, 3);
    for (int f = 0; f < 3; f++) begin
      waitValid(40, idle);
      checkOutput(f == 0 ? "t2 start latency" : "t2 gap idle cycles", 64'(idle), f == 0 ? 64'd2 : 64'd13);
      receiveFrame(100, -1, beats, dErr, pErr);
      checkOutput("t2 beats", 64'(beats), 64'd64);
      checkOutput("t2 data+protocol errors", 64'(dErr + pErr), 64'd0);
    end
    checkOutput("t2 frames_sent", frames_sent, 64'd4);
    waitValid(30, idle);
    checkOutput("t2 no fourth frame", 64'(idle), 64'd30);
    checkOutput("t2 busy after session", 64'(busy), 64'd0);

    // Test 3: 100-byte frame under random backpressure
    $display("[TB] test 3: 100-byte frame, 50%% tready");
    applyStimulus(1'b0, 100, 0, 1);
    step();
    applyStimulus(1'b1, 100, 0, 1);
    waitValid(10, idle);
    receiveFrame(50, -1, beats, dErr, pErr);
    checkOutput("t3 beats (tlast on byte 99)", 64'(beats), 64'd100);
    checkOutput("t3 data errors", 64'(dErr), 64'd0);
    checkOutput("t3 stall/protocol errors", 64'(pErr), 64'd0);
    checkOutput("t3 frames_sent", frames_sent, 64'd5);

    // Test 4: unlimited session, enable and frame_size change at byte 30
    $display("[TB] test 4: enable drop mid-frame");
    applyStimulus(1'b0, 60, 0, 0);
    step();
    applyStimulus(1'b1, 60, 0, 0);
    waitValid(10, idle);
    receiveFrame(100, 30, beats, dErr, pErr);
    checkOutput("t4 beats", 64'(beats), 64'd60);
    checkOutput("t4 data+protocol errors", 64'(dErr + pErr), 64'd0);
    checkOutput("t4 frames_sent", frames_sent, 64'd6);
    waitValid(20, idle);
    checkOutput("t4 no further frames", 64'(idle), 64'd20);
    checkOutput("t4 busy", 64'(busy), 64'd0);

    // Test 5: soft reset at byte 10, then replay
    $display("[TB] test 5: srst mid-frame");
    applyStimulus(1'b1, 60, 0, 1);
    waitValid(10, idle);
    repeat (10) step();
    checkOutput("t5 byte 10 on bus", 64'(m_axis_tdata), 64'(expMem[10]));
    srst = 1'b1;
    enable = 1'b0;
    step();
    srst = 1'b0;
    checkOutput("t5 tvalid after srst", 64'(m_axis_tvalid), 64'd0);
    checkOutput("t5 frames_sent after srst", frames_sent, 64'd0);
    checkOutput("t5 busy after srst", 64'(busy), 64'd0);
    checkOutput("t5 last_tx_time after srst", last_tx_time, 64'd0);
    applyStimulus(1'b1, 60, 0, 1);
    waitValid(10, idle);
    checkOutput("t5 restart latency", 64'(idle), 64'd2);
    receiveFrame(100, -1, beats, dErr, pErr);
    checkOutput("t5 replay beats", 64'(beats), 64'd60);
    checkOutput("t5 replay data+protocol errors", 64'(dErr + pErr), 64'd0);
    checkOutput("t5 frames_sent", frames_sent, 64'd1);

    // Test 6: oversize frame clamps to the buffer, then a single-byte frame
    $display("[TB] test 6: clamp and single beat");
    applyStimulus(1'b0, 4000, 0, 1);
    step();
    applyStimulus(1'b1, 4000, 0, 1);
    waitValid(10, idle);
    receiveFrame(100, -1, beats, dErr, pErr);
    checkOutput("t6 clamped beats", 64'(beats), 64'd2048);
    checkOutput("t6 data+protocol errors", 64'(dErr + pErr), 64'd0);
    checkOutput("t6 last_tx_time", last_tx_time, expTime);
    applyStimulus(1'b0, 1, 0, 1);
    step();
    applyStimulus(1'b1, 1, 0, 1);
    waitValid(10, idle);
    checkOutput("t6 single-beat tlast", 64'(m_axis_tlast), 64'd1);
    receiveFrame(100, -1, beats, dErr, pErr);
    checkOutput("t6 single beats", 64'(beats), 64'd1);
    checkOutput("t6 single data+protocol errors", 64'(dErr + pErr), 64'd0);
    checkOutput("t6 single last_tx_time", last_tx_time, expTime);
    checkOutput("t6 frames_sent", frames_sent, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
